// File: rtl/addsub_pkg.sv
// Shared constants, result-flag record and slice-width helper for the pipelined adder/subtractor.
package addsub_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_STAGES  = 2;
  localparam int unsigned DEF_SLICE_W = DEF_WIDTH / DEF_STAGES;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic int unsigned slice_w(input int unsigned w, input int unsigned s);
    return w / s;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// SW-bit ripple-carry slice with carry-in, carry-out and the carry into its top bit.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int unsigned SW = DEF_SLICE_W
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          cmsb
);

  logic [SW:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(SW); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SW];
  assign cmsb = c[SW-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: one SW-bit slice per stage, carry registered between stages,
// operand and result bits skewed so a whole result leaves together with valid/ready flow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SW = slice_w(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("addsub_pipe: WIDTH must be >= 2 and divisible by STAGES >= 1");
  end

  logic             adv;
  logic [WIDTH-1:0] bx;

  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];

  logic [SW-1:0]    sl_a  [STAGES];
  logic [SW-1:0]    sl_b  [STAGES];
  logic [SW-1:0]    sl_s  [STAGES];
  logic             sl_ci [STAGES];
  logic             sl_co [STAGES];
  logic             sl_cm [STAGES];

  logic [WIDTH-1:0] s_nx [STAGES];
  flags_t           fl_nx;
  flags_t           fl_q;

  // Subtraction is a + ~b + 1: invert b up front, carry-in of slice 0 is sub.
  assign bx  = b ^ {WIDTH{sub}};
  assign adv = out_ready | ~v_q[STAGES-1];

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
    addsub_slice #(.SW(SW)) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (sl_ci[k]),
      .s    (sl_s[k]),
      .cout (sl_co[k]),
      .cmsb (sl_cm[k])
    );
  end

  // Slice k takes its operand bits from the skew registers of stage k-1.
  always_comb begin
    sl_a[0]  = a[SW-1:0];
    sl_b[0]  = bx[SW-1:0];
    sl_ci[0] = sub;
    for (int k = 1; k < int'(STAGES); k++) begin
      sl_a[k]  = a_q[k-1][k*SW +: SW];
      sl_b[k]  = b_q[k-1][k*SW +: SW];
      sl_ci[k] = c_q[k-1];
    end
  end

  always_comb begin
    s_nx[0]        = '0;
    s_nx[0][SW-1:0] = sl_s[0];
    for (int k = 1; k < int'(STAGES); k++) begin
      s_nx[k]              = s_q[k-1];
      s_nx[k][k*SW +: SW]  = sl_s[k];
    end
    fl_nx.cout = sl_co[STAGES-1];
    fl_nx.ovf  = sl_co[STAGES-1] ^ sl_cm[STAGES-1];
    fl_nx.zero = (s_nx[STAGES-1] == '0);
  end

  // Whole pipeline moves together on adv; bubbles travel as invalid stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      fl_q <= '0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= bx;
      s_q[0] <= s_nx[0];
      c_q[0] <= sl_co[0];
      for (int k = 1; k < int'(STAGES); k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_nx[k];
        c_q[k] <= sl_co[k];
      end
      fl_q <= fl_nx;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = fl_q.cout;
  assign ovf       = fl_q.ovf;
  assign zero      = fl_q.zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: 8-bit/2-stage directed flow tests and 4-bit/1-stage exhaustive sweep.
module tb_addsub_pipe;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv8, ir8, sub8, ov8, or8, co8, of8, z8;
  logic [7:0] a8, b8, s8;
  logic       iv4, ir4, sub4, ov4, or4, co4, of4, z4;
  logic [3:0] a4, b4, s4;

  int checks = 0;
  int errors = 0;
  int n8 = 0;
  int n4 = 0;
  res_t q8[$];
  res_t q4[$];

  addsub_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8), .zero(z8)
  );

  addsub_pipe #(.WIDTH(4), .STAGES(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .sub(sub4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4), .zero(z4)
  );

  // Reference: plain integer arithmetic, overflow from operand/result signs.
  function automatic res_t model(input int unsigned w, input logic [7:0] a, input logic [7:0] b,
                                 input logic sub);
    int unsigned mask = (32'd1 << w) - 32'd1;
    int unsigned ai   = 32'(a) & mask;
    int unsigned bi   = 32'(b) & mask;
    int unsigned bb   = sub ? (~bi & mask) : bi;
    int unsigned t    = ai + bb + 32'(sub);
    res_t r;
    logic sa, sb, ss;
    r.sum  = 8'(t & mask);
    r.cout = ((t >> w) & 32'd1) != 0;
    sa     = ((ai >> (w - 1)) & 32'd1) != 0;
    sb     = ((bi >> (w - 1)) & 32'd1) != 0;
    ss     = ((32'(r.sum) >> (w - 1)) & 32'd1) != 0;
    r.ovf  = sub ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    r.zero = (r.sum == 8'h00);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle a result is presented it must match the oldest accepted set.
  always @(negedge clk) begin : mon
    res_t e;
    if (rst) begin
      q8.delete();
      q4.delete();
    end else begin
      chk("d8_in_ready", 32'(ir8), 32'(or8 || !ov8));
      if (ov8) begin
        if (q8.size() == 0) chk("d8_spurious_valid", 32'(ov8), 0);
        else begin
          e = q8[0];
          chk("d8_sum", 32'(s8), 32'(e.sum));
          chk("d8_cout", 32'(co8), 32'(e.cout));
          chk("d8_ovf", 32'(of8), 32'(e.ovf));
          chk("d8_zero", 32'(z8), 32'(e.zero));
          if (or8) begin
            void'(q8.pop_front());
            n8++;
          end
        end
      end
      if (iv8 && ir8) q8.push_back(model(8, a8, b8, sub8));

      chk("d4_in_ready", 32'(ir4), 32'(or4 || !ov4));
      if (ov4) begin
        if (q4.size() == 0) chk("d4_spurious_valid", 32'(ov4), 0);
        else begin
          e = q4[0];
          chk("d4_sum", 32'(s4), 32'(e.sum));
          chk("d4_cout", 32'(co4), 32'(e.cout));
          chk("d4_ovf", 32'(of4), 32'(e.ovf));
          chk("d4_zero", 32'(z4), 32'(e.zero));
          if (or4) begin
            void'(q4.pop_front());
            n4++;
          end
        end
      end
      if (iv4 && ir4) q4.push_back(model(4, {4'h0, a4}, {4'h0, b4}, sub4));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction into the 8-bit pipe; result expected exactly two edges after accept.
  task automatic send_one(input string nm, input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    a8 = a; b8 = b; sub8 = s; iv8 = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(ir8), 1);
    step();
    iv8 = 1'b0;
    @(negedge clk);
    chk({nm, "_not_yet_valid"}, 32'(ov8), 0);
    step();
    @(negedge clk);
    chk({nm, "_valid"}, 32'(ov8), 1);
    chk({nm, "_sum"}, 32'(s8), 32'(es));
    chk({nm, "_cout"}, 32'(co8), 32'(ec));
    chk({nm, "_ovf"}, 32'(of8), 32'(eo));
    chk({nm, "_zero"}, 32'(z8), 32'(ez));
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic [7:0] bba [4] = '{8'h01, 8'h7F, 8'hFF, 8'h80};
  logic [7:0] bbb [4] = '{8'h02, 8'h01, 8'h01, 8'h80};
  logic       bbs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin : stim
    res_t bbx [4];
    int   base;
    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; or8 = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; or4 = 1'b1;

    // Pin the reference model with hand-computed results.
    chk("model_5a_add_3c", 32'(model(8, 8'h5A, 8'h3C, 1'b0)), 32'({8'h96, 3'b010}));
    chk("model_10_sub_20", 32'(model(8, 8'h10, 8'h20, 1'b1)), 32'({8'hF0, 3'b000}));
    chk("model_80_sub_01", 32'(model(8, 8'h80, 8'h01, 1'b1)), 32'({8'h7F, 3'b110}));
    chk("model_33_sub_33", 32'(model(8, 8'h33, 8'h33, 1'b1)), 32'({8'h00, 3'b101}));
    chk("model4_7_add_1", 32'(model(4, 8'h07, 8'h01, 1'b0)), 32'({8'h08, 3'b010}));

    // Outputs in reset
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(ov8), 0);
    chk("rst_sum", 32'(s8), 0);
    chk("rst_flags", 32'({co8, of8, z8}), 0);
    chk("rst_out_valid4", 32'(ov4), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(ir8), 1);
    chk("post_rst_out_valid", 32'(ov8), 0);
    step();

    send_one("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    send_one("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    send_one("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    send_one("sub_33_33", 8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

    // Back-to-back: four accepts on consecutive edges, results visible cycles 2..5
    for (int i = 0; i < 4; i++) bbx[i] = model(8, bba[i], bbb[i], bbs[i]);
    for (int j = 0; j < 8; j++) begin
      if (j < 4) begin
        a8 = bba[j]; b8 = bbb[j]; sub8 = bbs[j]; iv8 = 1'b1;
      end else iv8 = 1'b0;
      @(negedge clk);
      chk("b2b_valid", 32'(ov8), (j >= 2 && j <= 5) ? 1 : 0);
      if (j >= 2 && j <= 5) chk("b2b_sum", 32'(s8), 32'(bbx[j-2].sum));
      step();
    end

    // Backpressure: fill both stages, stall three cycles, then drain
    base = n8;
    or8 = 1'b0;
    a8 = 8'h11; b8 = 8'h01; sub8 = 1'b0; iv8 = 1'b1;
    step();
    a8 = 8'h22; b8 = 8'h02;
    step();
    a8 = 8'h33; b8 = 8'h03;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(ir8), 0);
      chk("bp_out_valid", 32'(ov8), 1);
      chk("bp_sum_frozen", 32'(s8), 'h12);
      step();
    end
    or8 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(ir8), 1);
    step();
    iv8 = 1'b0;
    for (int k = 0; k < 20 && q8.size() != 0; k++) @(negedge clk);
    chk("bp_drained", 32'(q8.size()), 0);
    chk("bp_delivered", 32'(n8 - base), 3);
    step();

    // Reset with two transactions in flight
    a8 = 8'h44; b8 = 8'h01; sub8 = 1'b0; iv8 = 1'b1;
    step();
    a8 = 8'h55;
    step();
    iv8 = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_out_valid", 32'(ov8), 0);
    chk("midrst_sum", 32'(s8), 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_replay", 32'(ov8), 0);
      step();
    end

    // Exhaustive 4-bit, single stage
    base = n4;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int s = 0; s < 2; s++) begin
          a4 = 4'(x); b4 = 4'(y); sub4 = 1'(s); iv4 = 1'b1;
          step();
        end
    iv4 = 1'b0;
    for (int k = 0; k < 20 && q4.size() != 0; k++) @(negedge clk);
    chk("exh_drained", 32'(q4.size()), 0);
    chk("exh_count", 32'(n4 - base), 512);
    chk("final_q8_empty", 32'(q8.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 SHALL have parameter STAGES, default 2, pipeline stages (>= 1); WIDTH divisible by STAGES, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand set offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of MSB (sub: 1 = no borrow, a >= b unsigned).
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-015 SHALL have port zero  output  1  sum == 0.

Function
REQ-016 SHALL compute add as a + b + 0 and sub as a + ~b + 1 (b inverted, carry-in = sub).
REQ-017 SHALL split the datapath into STAGES slices of WIDTH/STAGES bits; slice k adds bits [k*W/S +: W/S] in stage k using the carry registered from stage k-1.
REQ-018 SHALL delay unconsumed operand bits and produced result bits with skew registers so all sum bits of one transaction leave together.
REQ-019 SHALL give latency exactly STAGES cycles from accept (in_valid & in_ready) to out_valid, with no out_ready stall.
REQ-020 SHALL sustain one transaction per cycle while out_ready stays high.
REQ-021 SHALL advance the whole pipeline when adv = out_ready | ~out_valid; in_ready = adv; when adv = 0 every stage register holds.
REQ-022 SHALL carry a valid bit per stage; bubbles propagate as invalid and are not collapsed.
REQ-023 SHALL hold sum/cout/ovf/zero stable while out_valid & ~out_ready.
REQ-024 SHALL set ovf = carry into MSB XOR carry out of MSB.
REQ-025 SHALL deliver results in acceptance order; no loss, no duplication under any out_ready pattern.
REQ-026 SHALL not accept operands when in_valid = 1 and in_ready = 0; the source holds them.

Reset
REQ-027 SHALL, on rst high at a clock edge, clear all stage valid bits, inter-stage carries and data registers to 0.
REQ-028 SHALL drive out_valid=0, sum=0, cout=0, ovf=0, zero=0 while held in reset; in_ready=1 from the first cycle after reset (out_valid=0).
REQ-029 SHALL discard in-flight transactions on reset mid-operation; none reappear afterwards.

Structure
REQ-030 SHALL place the stage-slice width constant and a result-flags record (cout, ovf, zero) in shared package addsub_pkg.
REQ-031 SHALL implement one slice adder sub-module, addsub_slice (W/S-bit ripple add with cin/cout and MSB carry-in tap), instantiated STAGES times.

Verification
REQ-032 SHALL check WIDTH=8, STAGES=2: a=0x5A, b=0x3C, sub=0 -> after 2 cycles sum=0x96, cout=0, ovf=1, zero=0.
REQ-033 SHALL check sub: 0x10-0x20 -> 0xF0, cout=0, ovf=0; 0x80-0x01 -> 0x7F, cout=1, ovf=1; 0x33-0x33 -> 0x00, cout=1, zero=1.
REQ-034 SHALL check back-to-back: 4 transactions on consecutive cycles, out_ready=1 -> 4 results on consecutive cycles, cycles 2..5, in order.
REQ-035 SHALL check backpressure: out_ready=0 for 3 cycles with pipeline full -> in_ready=0, outputs frozen, no loss once out_ready=1.
REQ-036 SHALL check reset mid-flight: rst pulse with 2 transactions in flight -> out_valid=0 next cycle, neither result ever emitted.
REQ-037 SHALL check WIDTH=4, STAGES=1 exhaustively (all a, b, sub) against a reference model for sum, cout, ovf, zero.
